// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: word type, queue entry and fetch FSM states.
package instruction_fetch_queue_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } ifq_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DISCARD
    } fetch_state_t;

    localparam word_t INSTR_BYTES = 32'd4;

endpackage

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// Power-of-two FIFO of {pc, instr} entries with push/pop/clear and registered pointers.
module fetch_fifo
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  ifq_entry_t push_data,
    output ifq_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    ifq_entry_t       mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: one blocking imem read at a time, PC-advance strobe, FIFO to decode.
// Optional macro IFQ_BYPASS_EN forwards a hit straight to decode when the queue is empty.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pcaddr,
    output logic        pc_adv,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        flush,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_npc,
    input  logic        decode_ready
);

    fetch_state_t state_q, state_d;
    word_t        req_addr_q, req_addr_d;
    logic         hit_ok;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    ifq_entry_t   fifo_head;
    ifq_entry_t   new_entry;
    ifq_entry_t   out_entry;

    assign hit_ok    = (state_q == FETCH) && ihit && !flush;
    assign pc_adv    = hit_ok;
    assign imemREN   = (state_q != IDLE);
    assign imemaddr  = req_addr_q;
    assign new_entry = '{pc: req_addr_q, instr: imemload};

`ifdef IFQ_BYPASS_EN
    logic bypass;
    assign bypass      = hit_ok && fifo_empty;
    assign fifo_push   = hit_ok && !(bypass && decode_ready);
    assign out_entry   = bypass ? new_entry : fifo_head;
    assign instr_valid = !fifo_empty || bypass;
`else
    assign fifo_push   = hit_ok;
    assign out_entry   = fifo_head;
    assign instr_valid = !fifo_empty;
`endif

    // A pop in a flush cycle is void; the FIFO also ignores it under clear.
    assign fifo_pop  = instr_valid && decode_ready && !flush && !fifo_empty;
    assign instr     = instr_valid ? out_entry.instr : '0;
    assign instr_pc  = instr_valid ? out_entry.pc : '0;
    assign instr_npc = instr_pc + INSTR_BYTES;

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        case (state_q)
            IDLE: begin
                if (!fifo_full && !flush) begin
                    req_addr_d = pcaddr;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (ihit)       state_d = IDLE;
                else if (flush) state_d = DISCARD;
            end
            DISCARD: begin
                if (ihit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .n_rst    (nRST),
        .clear    (flush),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .push_data(new_entry),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Table-driven bench for instruction_fetch_queue (default build, DEPTH=2) with a decode-side scoreboard.
module tb_instruction_fetch_queue;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] pcaddr;
    logic        pc_adv;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_npc;
    logic        decode_ready;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    instruction_fetch_queue #(.DEPTH(2)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .pcaddr      (pcaddr),
        .pc_adv      (pc_adv),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .ihit        (ihit),
        .imemload    (imemload),
        .flush       (flush),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_npc   (instr_npc),
        .decode_ready(decode_ready)
    );

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] load;
        logic        fl;
        logic        rdy;
        logic        e_ren;
        logic [31:0] e_addr;
        logic        e_adv;
        logic        e_vld;
        logic [31:0] e_ipc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] pc, input logic hit, input logic [31:0] load,
                       input logic fl, input logic rdy, input logic e_ren,
                       input logic [31:0] e_addr, input logic e_adv, input logic e_vld,
                       input logic [31:0] e_ipc);
        vec_t v;
        v.pc = pc; v.hit = hit; v.load = load; v.fl = fl; v.rdy = rdy;
        v.e_ren = e_ren; v.e_addr = e_addr; v.e_adv = e_adv; v.e_vld = e_vld; v.e_ipc = e_ipc;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] npc;

        //   pc            hit load          fl rdy  ren addr          adv vld ipc
        add(32'h0,         0, 32'h0,         0, 1,   0, 32'h0,         0, 0, 32'h0);
        add(32'h0,         1, 32'h1111_0000, 0, 1,   1, 32'h0,         1, 0, 32'h0);
        add(32'h4,         0, 32'h0,         0, 1,   0, 32'h0,         0, 1, 32'h0);
        add(32'h4,         1, 32'h1111_0001, 0, 1,   1, 32'h4,         1, 0, 32'h0);
        add(32'h8,         0, 32'h0,         0, 1,   0, 32'h4,         0, 1, 32'h4);
        add(32'h8,         1, 32'h1111_0002, 0, 0,   1, 32'h8,         1, 0, 32'h0);
        add(32'hC,         0, 32'h0,         0, 0,   0, 32'h8,         0, 1, 32'h8);
        add(32'hC,         1, 32'h1111_0003, 0, 0,   1, 32'hC,         1, 1, 32'h8);
        add(32'h10,        0, 32'h0,         0, 0,   0, 32'hC,         0, 1, 32'h8);
        add(32'h10,        0, 32'h0,         0, 0,   0, 32'hC,         0, 1, 32'h8);
        add(32'h10,        0, 32'h0,         0, 1,   0, 32'hC,         0, 1, 32'h8);
        add(32'h10,        0, 32'h0,         0, 0,   0, 32'hC,         0, 1, 32'hC);
        add(32'h40,        0, 32'h0,         1, 0,   1, 32'h10,        0, 1, 32'hC);
        add(32'h40,        0, 32'h0,         0, 1,   1, 32'h10,        0, 0, 32'h0);
        add(32'h40,        1, 32'hDEAD_BEEF, 0, 1,   1, 32'h10,        0, 0, 32'h0);
        add(32'h40,        0, 32'h0,         1, 1,   0, 32'h10,        0, 0, 32'h0);
        add(32'h40,        0, 32'h0,         0, 1,   0, 32'h10,        0, 0, 32'h0);
        add(32'h40,        0, 32'h0,         0, 0,   1, 32'h40,        0, 0, 32'h0);
        add(32'h40,        0, 32'h0,         0, 0,   1, 32'h40,        0, 0, 32'h0);
        add(32'h40,        0, 32'h0,         0, 0,   1, 32'h40,        0, 0, 32'h0);
        add(32'h40,        1, 32'h2222_0000, 0, 0,   1, 32'h40,        1, 0, 32'h0);
        add(32'h44,        0, 32'h0,         0, 0,   0, 32'h40,        0, 1, 32'h40);
        add(32'h44,        1, 32'h2222_0001, 1, 1,   1, 32'h44,        0, 1, 32'h40);
        add(32'h44,        0, 32'h0,         0, 1,   0, 32'h44,        0, 0, 32'h0);
        add(32'h44,        1, 32'h2222_0001, 0, 1,   1, 32'h44,        1, 0, 32'h0);
        add(32'hFFFF_FFFC, 0, 32'h0,         0, 1,   0, 32'h44,        0, 1, 32'h44);
        add(32'hFFFF_FFFC, 1, 32'h3333_0000, 0, 1,   1, 32'hFFFF_FFFC, 1, 0, 32'h0);
        add(32'h0,         0, 32'h0,         0, 1,   0, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC);
        add(32'h0,         0, 32'h0,         0, 1,   1, 32'h0,         0, 0, 32'h0);

        // Reset with a hit asserted: the hit must be ignored.
        nRST = 1'b0; pcaddr = 32'h0; ihit = 1'b1; imemload = 32'hFFFF_FFFF;
        flush = 1'b0; decode_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset imemREN",     {31'd0, imemREN},     32'd0);
        chk("reset imemaddr",    imemaddr,             32'd0);
        chk("reset pc_adv",      {31'd0, pc_adv},      32'd0);
        chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("reset instr",       instr,                32'd0);
        chk("reset instr_pc",    instr_pc,             32'd0);
        chk("reset instr_npc",   instr_npc,            32'd4);

        @(posedge CLK); #1;
        nRST = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            pcaddr = vecs[i].pc; ihit = vecs[i].hit; imemload = vecs[i].load;
            flush = vecs[i].fl; decode_ready = vecs[i].rdy;
            @(negedge CLK);
            chk($sformatf("row%0d imemREN", i),     {31'd0, imemREN},     {31'd0, vecs[i].e_ren});
            chk($sformatf("row%0d imemaddr", i),    imemaddr,             vecs[i].e_addr);
            chk($sformatf("row%0d pc_adv", i),      {31'd0, pc_adv},      {31'd0, vecs[i].e_adv});
            chk($sformatf("row%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_vld});
            chk($sformatf("row%0d instr_pc", i),    instr_pc,             vecs[i].e_ipc);
            if (vecs[i].fl) begin
                sb.delete();
            end else begin
                if (instr_valid && vecs[i].rdy) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL row%0d pop: decode accepted pc %h but nothing expected", i, instr_pc);
                    end else begin
                        e = sb.pop_front();
                        npc = e.pc + 32'd4;
                        chk($sformatf("row%0d sb instr", i),     instr,     e.ins);
                        chk($sformatf("row%0d sb instr_pc", i),  instr_pc,  e.pc);
                        chk($sformatf("row%0d sb instr_npc", i), instr_npc, npc);
                    end
                end
                if (vecs[i].hit && vecs[i].e_ren && vecs[i].e_adv)
                    sb.push_back('{pc: vecs[i].e_addr, ins: vecs[i].load});
            end
            @(posedge CLK); #1;
        end
        chk("scoreboard drained", sb.size(), 32'd0);

        // Asynchronous reset mid-request (FSM is in FETCH) with a hit present.
        ihit = 1'b1; imemload = 32'h4444_0000; nRST = 1'b0;
        #1;
        chk("async rst imemREN",  {31'd0, imemREN}, 32'd0);
        chk("async rst imemaddr", imemaddr,         32'd0);
        chk("async rst pc_adv",   {31'd0, pc_adv},  32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1; ihit = 1'b0; pcaddr = 32'h100;
        @(negedge CLK);
        chk("post rst idle imemREN", {31'd0, imemREN}, 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("post rst fetch imemREN",  {31'd0, imemREN}, 32'd1);
        chk("post rst fetch imemaddr", imemaddr,         32'h100);
        chk("post rst instr_valid",    {31'd0, instr_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
